// File: rtl/hexldr_pkg.sv
// Shared types and helpers for the ASCII-hex UART loader.
// FSM state encoding, command characters and the hex-character classifier.
package hexldr_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_WRITE  = 2'd2,
    S_ECHO   = 2'd3
  } state_t;

  localparam logic [7:0] CH_RESTART = 8'h52;
  localparam logic [7:0] CH_GO      = 8'h47;

  // Returns {valid, nibble}; letters share the same low-nibble offset in both cases.
  function automatic logic [4:0] hex_val(input logic [7:0] b);
    logic [4:0] r;
    r = 5'd0;
    if (b >= 8'h30 && b <= 8'h39) begin
      r = {1'b1, b[3:0]};
    end else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) begin
      r = {1'b1, b[3:0] + 4'd9};
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_hex_loader_decode.sv
// Combinational classifier for one received byte: hex digit, restart or go.
module hex_ascii_decode
  import hexldr_pkg::*;
(
  input  logic [7:0] byte_in,
  output logic       is_hex,
  output logic [3:0] nibble,
  output logic       is_restart,
  output logic       is_go
);

  logic [4:0] hv;

  assign hv         = hex_val(byte_in);
  assign is_hex     = hv[4];
  assign nibble     = hv[3:0];
  assign is_restart = (byte_in == CH_RESTART);
  assign is_go      = (byte_in == CH_GO);

endmodule

// File: rtl/uart_hex_loader.sv
// ASCII-hex loader: assembles WORD_W-bit words (MSB nibble first) from UART bytes and writes them
// to consecutive memory addresses. Define HEXLDR_CHKSUM_EN to build the running byte checksum.
module uart_hex_loader
  import hexldr_pkg::*;
#(
  parameter int  WORD_W  = 32,
  parameter int  DEPTH   = 16,
  parameter bit  ECHO_EN = 1'b1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_rdy,
  output logic              rx_clr,
  output logic [7:0]        tx_data,
  output logic              tx_wr,
  input  logic              tx_busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [ADDR_W:0]   word_cnt,
  output logic              load_done,
  output logic              overflow,
  output logic [7:0]        chksum
);

  localparam int                NIB       = WORD_W / 4;
  localparam int                NC_W      = $clog2(NIB + 1);
  localparam logic [NC_W-1:0]   NIB_LAST  = NC_W'(NIB - 1);
  localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_LAST  = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [7:0]          byte_q, byte_d;
  logic [WORD_W-1:0]   sr_q, sr_d;
  logic [NC_W-1:0]     nib_cnt_q, nib_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
  logic                load_done_q, load_done_d;
  logic                overflow_q, overflow_d;
  logic                rx_clr_q, rx_clr_d;
  logic                tx_wr_q, tx_wr_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic                is_hex, is_restart, is_go;
  logic [3:0]          nibble;

  hex_ascii_decode u_decode (
    .byte_in    (byte_q),
    .is_hex     (is_hex),
    .nibble     (nibble),
    .is_restart (is_restart),
    .is_go      (is_go)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (rx_rdy) state_d = S_DECODE;
      S_DECODE: begin
        if (is_hex && nib_cnt_q == NIB_LAST) state_d = S_WRITE;
        else                                 state_d = ECHO_EN ? S_ECHO : S_IDLE;
      end
      S_WRITE:  state_d = ECHO_EN ? S_ECHO : S_IDLE;
      S_ECHO:   if (!tx_busy) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Strobes are registered so each lands one cycle after the state that issues it.
  always_comb begin
    byte_d      = byte_q;
    sr_d        = sr_q;
    nib_cnt_d   = nib_cnt_q;
    addr_d      = addr_q;
    word_cnt_d  = word_cnt_q;
    load_done_d = load_done_q;
    overflow_d  = overflow_q;
    rx_clr_d    = 1'b0;
    tx_wr_d     = 1'b0;
    tx_data_d   = tx_data_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (rx_rdy) begin
          byte_d   = rx_data;
          rx_clr_d = 1'b1;
        end
      end
      S_DECODE: begin
        if (is_hex) begin
          sr_d      = {sr_q[WORD_W-5:0], nibble};
          nib_cnt_d = (nib_cnt_q == NIB_LAST) ? '0 : nib_cnt_q + 1'b1;
        end else if (is_restart) begin
          addr_d      = '0;
          word_cnt_d  = '0;
          nib_cnt_d   = '0;
          load_done_d = 1'b0;
          overflow_d  = 1'b0;
        end else if (is_go) begin
          load_done_d = 1'b1;
          nib_cnt_d   = '0;
        end
      end
      S_WRITE: begin
        if (word_cnt_q < CNT_FULL) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = sr_q;
          word_cnt_d  = word_cnt_q + 1'b1;
          if (addr_q != ADDR_LAST)     addr_d      = addr_q + 1'b1;
          if (word_cnt_q == CNT_LAST)  load_done_d = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end
      S_ECHO: begin
        if (!tx_busy) begin
          tx_wr_d   = 1'b1;
          tx_data_d = byte_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_q      <= '0;
      sr_q        <= '0;
      nib_cnt_q   <= '0;
      addr_q      <= '0;
      word_cnt_q  <= '0;
      load_done_q <= 1'b0;
      overflow_q  <= 1'b0;
      rx_clr_q    <= 1'b0;
      tx_wr_q     <= 1'b0;
      tx_data_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      byte_q      <= byte_d;
      sr_q        <= sr_d;
      nib_cnt_q   <= nib_cnt_d;
      addr_q      <= addr_d;
      word_cnt_q  <= word_cnt_d;
      load_done_q <= load_done_d;
      overflow_q  <= overflow_d;
      rx_clr_q    <= rx_clr_d;
      tx_wr_q     <= tx_wr_d;
      tx_data_q   <= tx_data_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

`ifdef HEXLDR_CHKSUM_EN
  logic [7:0] chksum_q, chksum_d;

  function automatic logic [7:0] byte_sum(input logic [WORD_W-1:0] w);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < WORD_W / 8; i++) s = s + w[i*8 +: 8];
    return s;
  endfunction

  // Advances on the same edge that raises mem_we, so both are visible together.
  always_comb begin
    chksum_d = chksum_q;
    if (state_q == S_DECODE && is_restart)                    chksum_d = '0;
    else if (state_q == S_WRITE && word_cnt_q < CNT_FULL)     chksum_d = chksum_q + byte_sum(sr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chksum_q <= '0;
    else     chksum_q <= chksum_d;
  end

  assign chksum = chksum_q;
`else
  assign chksum = 8'h00;
`endif

  assign rx_clr    = rx_clr_q;
  assign tx_data   = tx_data_q;
  assign tx_wr     = tx_wr_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign word_cnt  = word_cnt_q;
  assign load_done = load_done_q;
  assign overflow  = overflow_q;

endmodule
